bcd_digit_renderer: RTL and testbench



---
 rtl/ssd_font_pkg.sv | 50 +++++
 rtl/digit_font_rom.sv | 15 +
 rtl/bcd_digit_renderer.sv | 186 ++++++++++++++++++
 tb/tb_bcd_digit_renderer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ssd_font_pkg.sv
// Shared types for the BCD digit renderer: glyph codes, 8x8 font table and
// renderer FSM states.
package ssd_font_pkg;

    typedef logic [3:0] glyph_t;

    localparam glyph_t GLYPH_DASH  = 4'd10;
    localparam glyph_t GLYPH_BLANK = 4'd15;

    // Column-major 8x8 font, bit0 of each byte is the top pixel row.
    // Codes 11..14 are unused and render as blank.
    localparam logic [7:0] FONT [16][8] = '{
        '{8'h00, 8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00, 8'h00},  // 0
        '{8'h00, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00, 8'h00},  // 1
        '{8'h00, 8'h42, 8'h61, 8'h51, 8'h49, 8'h46, 8'h00, 8'h00},  // 2
        '{8'h00, 8'h21, 8'h41, 8'h45, 8'h4B, 8'h31, 8'h00, 8'h00},  // 3
        '{8'h00, 8'h18, 8'h14, 8'h12, 8'h7F, 8'h10, 8'h00, 8'h00},  // 4
        '{8'h00, 8'h27, 8'h45, 8'h45, 8'h45, 8'h39, 8'h00, 8'h00},  // 5
        '{8'h00, 8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30, 8'h00, 8'h00},  // 6
        '{8'h00, 8'h01, 8'h71, 8'h09, 8'h05, 8'h03, 8'h00, 8'h00},  // 7
        '{8'h00, 8'h36, 8'h49, 8'h49, 8'h49, 8'h36, 8'h00, 8'h00},  // 8
        '{8'h00, 8'h06, 8'h49, 8'h49, 8'h29, 8'h1E, 8'h00, 8'h00},  // 9
        '{8'h00, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00},  // dash
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}   // blank
    };

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_WAIT_SYNC,
        ST_EMIT,
        ST_WAIT_EMIT,
        ST_DONE
    } state_t;

    // Blanked digits win; any nibble above 9 is shown as a dash.
    function automatic glyph_t nibble_to_glyph(input logic [3:0] nib, input logic blank);
        if (blank)
            return GLYPH_BLANK;
        else if (nib > 4'd9)
            return GLYPH_DASH;
        else
            return nib;
    endfunction

endpackage

// File: rtl/digit_font_rom.sv
// Combinational font lookup: glyph code and column index to column byte.
module digit_font_rom
    import ssd_font_pkg::*;
(
    input  logic [3:0] i_glyph,
    input  logic [2:0] i_col,
    output logic [7:0] o_byte
);

    // Pure table lookup, no state.
    always_comb begin
        o_byte = FONT[i_glyph][i_col];
    end

endmodule

// File: rtl/bcd_digit_renderer.sv
// Renders a latched BCD value as font columns into the SSD1306 driver:
// one cursor sync followed by DIGITS_NUM*FONT_WIDTH data writes per refresh,
// with optional leading-zero blanking and dash marking of invalid nibbles.
module bcd_digit_renderer
    import ssd_font_pkg::*;
#(
    parameter int unsigned DIGITS_NUM    = 6,
    parameter int unsigned FONT_WIDTH    = 8,
    parameter bit          BLANK_LEADING = 1'b1
) (
    input  logic                    clk_in,
    input  logic                    resetn_in,
    input  logic [4*DIGITS_NUM-1:0] digits_in,
    input  logic                    refresh_stb_in,
    output logic                    ready_out,
    output logic [7:0]              oled_data_out,
    output logic                    oled_write_stb_out,
    output logic                    oled_sync_stb_out,
    input  logic                    oled_ready_in
);

    localparam int unsigned      DIG_W      = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1;
    localparam logic [DIG_W-1:0] LAST_DIGIT = DIG_W'(DIGITS_NUM - 1);
    localparam logic [2:0]       LAST_COL   = 3'(FONT_WIDTH - 1);

    state_t                  r_state, w_state_nxt;
    logic [4*DIGITS_NUM-1:0] r_digits, w_digits_nxt;
    logic [DIGITS_NUM-1:0]   r_blank, w_blank_nxt;     // bit 0 = most significant digit
    logic [DIG_W-1:0]        r_digit, w_digit_nxt;     // 0 = most significant digit
    logic [2:0]              r_col, w_col_nxt;
    logic                    r_seen_low, w_seen_low_nxt;
    logic [7:0]              r_data, w_data_nxt;
    logic                    r_wr_stb, w_wr_stb_nxt;
    logic                    r_sync_stb, w_sync_stb_nxt;
    logic                    r_ready, w_ready_nxt;

    logic [DIGITS_NUM-1:0]   w_blank_in;
    logic                    w_lead;
    logic [3:0]              w_nibble;
    logic                    w_blank_sel;
    glyph_t                  w_glyph;
    logic [7:0]              w_font_byte;
    logic                    w_strobe_ok;

    // Leading-zero mask of the incoming value, walked from the most significant digit.
    always_comb begin
        w_blank_in = '0;
        w_lead     = BLANK_LEADING;
        for (int unsigned k = 0; k < DIGITS_NUM; k++) begin
            if (digits_in[4*(DIGITS_NUM-1-k) +: 4] != 4'd0)
                w_lead = 1'b0;
            w_blank_in[k] = w_lead && (k != DIGITS_NUM - 1);
        end
    end

    // Select the nibble and blank flag of the digit currently being drawn.
    always_comb begin
        w_nibble    = '0;
        w_blank_sel = 1'b0;
        for (int unsigned k = 0; k < DIGITS_NUM; k++) begin
            if (r_digit == DIG_W'(k)) begin
                w_nibble    = r_digits[4*(DIGITS_NUM-1-k) +: 4];
                w_blank_sel = r_blank[k];
            end
        end
        w_glyph = nibble_to_glyph(w_nibble, w_blank_sel);
    end

    digit_font_rom u_font_rom (
        .i_glyph (w_glyph),
        .i_col   (r_col),
        .o_byte  (w_font_byte)
    );

    // A strobe needs a ready driver and a quiet previous cycle.
    assign w_strobe_ok = oled_ready_in && !r_wr_stb && !r_sync_stb;

    // Next-state and registered-output logic of the render sequencer.
    always_comb begin
        w_state_nxt    = r_state;
        w_digits_nxt   = r_digits;
        w_blank_nxt    = r_blank;
        w_digit_nxt    = r_digit;
        w_col_nxt      = r_col;
        w_seen_low_nxt = r_seen_low;
        w_data_nxt     = r_data;
        w_wr_stb_nxt   = 1'b0;
        w_sync_stb_nxt = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (refresh_stb_in) begin
                    w_digits_nxt = digits_in;
                    w_blank_nxt  = w_blank_in;
                    w_digit_nxt  = '0;
                    w_col_nxt    = '0;
                    w_state_nxt  = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (w_strobe_ok) begin
                    w_sync_stb_nxt = 1'b1;
                    w_seen_low_nxt = 1'b0;
                    w_state_nxt    = ST_WAIT_SYNC;
                end
            end
            ST_WAIT_SYNC: begin
                if (!oled_ready_in) begin
                    w_seen_low_nxt = 1'b1;
                end else if (r_seen_low) begin
                    w_digit_nxt = '0;
                    w_col_nxt   = '0;
                    w_state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (w_strobe_ok) begin
                    w_data_nxt     = w_font_byte;
                    w_wr_stb_nxt   = 1'b1;
                    w_seen_low_nxt = 1'b0;
                    w_state_nxt    = ST_WAIT_EMIT;
                end
            end
            ST_WAIT_EMIT: begin
                if (!oled_ready_in) begin
                    w_seen_low_nxt = 1'b1;
                end else if (r_seen_low) begin
                    if (r_col == LAST_COL) begin
                        w_col_nxt = '0;
                        if (r_digit == LAST_DIGIT) begin
                            w_state_nxt = ST_DONE;
                        end else begin
                            w_digit_nxt = r_digit + 1'b1;
                            w_state_nxt = ST_EMIT;
                        end
                    end else begin
                        w_col_nxt   = r_col + 3'd1;
                        w_state_nxt = ST_EMIT;
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // ready_out is registered, so it tracks the state being entered.
        w_ready_nxt = (w_state_nxt == ST_IDLE);
    end

    // State, counters, shadow value and registered outputs.
    always_ff @(posedge clk_in or negedge resetn_in) begin
        if (!resetn_in) begin
            r_state    <= ST_IDLE;
            r_digits   <= '0;
            r_blank    <= '0;
            r_digit    <= '0;
            r_col      <= '0;
            r_seen_low <= 1'b0;
            r_data     <= '0;
            r_wr_stb   <= 1'b0;
            r_sync_stb <= 1'b0;
            r_ready    <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_digits   <= w_digits_nxt;
            r_blank    <= w_blank_nxt;
            r_digit    <= w_digit_nxt;
            r_col      <= w_col_nxt;
            r_seen_low <= w_seen_low_nxt;
            r_data     <= w_data_nxt;
            r_wr_stb   <= w_wr_stb_nxt;
            r_sync_stb <= w_sync_stb_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign ready_out          = r_ready;
    assign oled_data_out      = r_data;
    assign oled_write_stb_out = r_wr_stb;
    assign oled_sync_stb_out  = r_sync_stb;

endmodule

// File: tb/tb_bcd_digit_renderer.sv
// Self-checking bench for bcd_digit_renderer: a default instance and a
// BLANK_LEADING=0 instance run in lockstep against a simple driver model.
module tb_bcd_digit_renderer;

    localparam logic [7:0] TB_FONT [16][8] = '{
        '{8'h00, 8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h42, 8'h7F, 8'h40, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h42, 8'h61, 8'h51, 8'h49, 8'h46, 8'h00, 8'h00},
        '{8'h00, 8'h21, 8'h41, 8'h45, 8'h4B, 8'h31, 8'h00, 8'h00},
        '{8'h00, 8'h18, 8'h14, 8'h12, 8'h7F, 8'h10, 8'h00, 8'h00},
        '{8'h00, 8'h27, 8'h45, 8'h45, 8'h45, 8'h39, 8'h00, 8'h00},
        '{8'h00, 8'h3C, 8'h4A, 8'h49, 8'h49, 8'h30, 8'h00, 8'h00},
        '{8'h00, 8'h01, 8'h71, 8'h09, 8'h05, 8'h03, 8'h00, 8'h00},
        '{8'h00, 8'h36, 8'h49, 8'h49, 8'h49, 8'h36, 8'h00, 8'h00},
        '{8'h00, 8'h06, 8'h49, 8'h49, 8'h29, 8'h1E, 8'h00, 8'h00},
        '{8'h00, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
        '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}
    };

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        refresh = 1'b0;
    logic        drv_ready = 1'b1;
    logic [23:0] digits = '0;
    logic        rdy, wr, sync, rdy_nb, wr_nb, sync_nb;
    logic [7:0]  data, data_nb;

    int checks = 0;
    int errors = 0;
    int stall_at = 0;
    int drv_cnt = 0;
    int drv_wcount = 0;

    logic [7:0] exp_q[$], exp_nb_q[$], got_q[$], got_nb_q[$];

    always #5 clk = ~clk;

    bcd_digit_renderer dut (
        .clk_in (clk), .resetn_in (rstn), .digits_in (digits),
        .refresh_stb_in (refresh), .ready_out (rdy), .oled_data_out (data),
        .oled_write_stb_out (wr), .oled_sync_stb_out (sync), .oled_ready_in (drv_ready)
    );

    bcd_digit_renderer #(.BLANK_LEADING(1'b0)) dut_nb (
        .clk_in (clk), .resetn_in (rstn), .digits_in (digits),
        .refresh_stb_in (refresh), .ready_out (rdy_nb), .oled_data_out (data_nb),
        .oled_write_stb_out (wr_nb), .oled_sync_stb_out (sync_nb), .oled_ready_in (drv_ready)
    );

    // Driver model: busy for 3 cycles after each strobe, 103 after write #stall_at.
    always @(posedge clk) begin
        #1;
        if (!rstn) begin
            drv_ready = 1'b1; drv_cnt = 0; drv_wcount = 0;
        end else if (wr || sync) begin
            drv_ready = 1'b0;
            if (sync) drv_wcount = 0; else drv_wcount++;
            drv_cnt = (wr && drv_wcount == stall_at) ? 103 : 3;
        end else if (drv_cnt > 0) begin
            drv_cnt--;
            if (drv_cnt == 0) drv_ready = 1'b1;
        end
    end

    // Expected bytes for six glyph codes, most significant first.
    task automatic push_frame(input bit nb, input logic [23:0] glyphs);
        logic [3:0] gl;
        for (int k = 0; k < 6; k++) begin
            gl = glyphs[4*(5-k) +: 4];
            for (int c = 0; c < 8; c++)
                if (nb) exp_nb_q.push_back(TB_FONT[gl][c]);
                else    exp_q.push_back(TB_FONT[gl][c]);
        end
    endtask

    task automatic start_refresh(input logic [23:0] d);
        @(negedge clk);
        digits  = d;
        refresh = 1'b1;
    endtask

    // Records written bytes and strobe-protocol violations until ready_out returns.
    task automatic capture(input int stop_after, input int mid_write,
                           output int n_wr, output int n_sync, output int viol,
                           output int max_gap, output bit tmo);
        bit prev_stb, low_seen, prev_rdy, stb;
        int gap;
        n_wr = 0; n_sync = 0; viol = 0; max_gap = 0; tmo = 1'b1;
        prev_stb = 1'b0; low_seen = 1'b0; gap = 0;
        prev_rdy = drv_ready;
        got_q.delete(); got_nb_q.delete();
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(negedge clk);
            refresh = 1'b0;
            stb = wr | sync;
            gap++;
            if (stb) begin
                if (prev_stb || !prev_rdy || (wr && sync) || (wr && !low_seen)) viol++;
                if (gap > max_gap) max_gap = gap;
                gap = 0;
                low_seen = 1'b0;
            end
            if (sync) n_sync++;
            if (wr) begin
                got_q.push_back(data);
                got_nb_q.push_back(data_nb);
                n_wr++;
                if (n_wr == mid_write) begin
                    digits  = 24'h999999;
                    refresh = 1'b1;
                end
            end
            if (!drv_ready) low_seen = 1'b1;
            prev_stb = stb;
            prev_rdy = drv_ready;
            if ((stop_after != 0 && n_wr == stop_after) || rdy) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", rdy); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_wr: got %b want 0", wr); end
        checks++; if (sync !== 1'b0) begin errors++; $display("FAIL reset_sync: got %b want 0", sync); end
        checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data); end
        checks++; if (data_nb !== 8'h00) begin errors++; $display("FAIL reset_data_nb: got %h want 00", data_nb); end
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rdy !== 1'b1 || wr !== 1'b0 || sync !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: ready=%b wr=%b sync=%b want 1/0/0", rdy, wr, sync);
        end
    endtask

    task automatic test_value42;
        int n_wr, n_sync, viol, gap; bit tmo; logic [7:0] e, g;
        exp_q.delete(); exp_nb_q.delete();
        push_frame(1'b0, 24'hFFFF42);
        push_frame(1'b1, 24'h000042);
        start_refresh(24'h000042);
        capture(0, 0, n_wr, n_sync, viol, gap, tmo);
        checks++; if (n_sync !== 1 || n_wr !== 48 || viol !== 0 || tmo !== 1'b0) begin
            errors++; $display("FAIL value42_frame: sync=%0d writes=%0d viol=%0d timeout=%0d want 1/48/0/0", n_sync, n_wr, viol, tmo);
        end
        for (int i = 0; i < 48; i++) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL value42_byte%0d: got %h want %h", i, g, e); end
            e = exp_nb_q.pop_front(); g = (got_nb_q.size() > 0) ? got_nb_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL value42_nb_byte%0d: got %h want %h", i, g, e); end
        end
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL value42_ready: got %b want 1", rdy); end
    endtask

    task automatic test_zero;
        int n_wr, n_sync, viol, gap; bit tmo; logic [7:0] e, g;
        exp_q.delete(); exp_nb_q.delete();
        push_frame(1'b0, 24'hFFFFF0);
        push_frame(1'b1, 24'h000000);
        start_refresh(24'h000000);
        capture(0, 0, n_wr, n_sync, viol, gap, tmo);
        checks++; if (n_sync !== 1 || n_wr !== 48 || viol !== 0 || tmo !== 1'b0) begin
            errors++; $display("FAIL zero_frame: sync=%0d writes=%0d viol=%0d timeout=%0d want 1/48/0/0", n_sync, n_wr, viol, tmo);
        end
        for (int i = 0; i < 48; i++) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL zero_byte%0d: got %h want %h", i, g, e); end
            e = exp_nb_q.pop_front(); g = (got_nb_q.size() > 0) ? got_nb_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL zero_nb_byte%0d: got %h want %h", i, g, e); end
        end
    endtask

    task automatic test_dash;
        int n_wr, n_sync, viol, gap; bit tmo; logic [7:0] e, g;
        exp_q.delete(); exp_nb_q.delete();
        push_frame(1'b0, 24'h12A456);
        push_frame(1'b1, 24'h12A456);
        start_refresh(24'h12A456);
        capture(0, 0, n_wr, n_sync, viol, gap, tmo);
        checks++; if (n_sync !== 1 || n_wr !== 48 || viol !== 0 || tmo !== 1'b0) begin
            errors++; $display("FAIL dash_frame: sync=%0d writes=%0d viol=%0d timeout=%0d want 1/48/0/0", n_sync, n_wr, viol, tmo);
        end
        for (int i = 0; i < 48; i++) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL dash_byte%0d: got %h want %h", i, g, e); end
            e = exp_nb_q.pop_front(); g = (got_nb_q.size() > 0) ? got_nb_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL dash_nb_byte%0d: got %h want %h", i, g, e); end
        end
    endtask

    task automatic test_ignore_refresh;
        int n_wr, n_sync, viol, gap, extra; bit tmo; logic [7:0] e, g;
        exp_q.delete();
        push_frame(1'b0, 24'h305007);
        start_refresh(24'h305007);
        capture(0, 5, n_wr, n_sync, viol, gap, tmo);
        checks++; if (n_sync !== 1 || n_wr !== 48 || viol !== 0 || tmo !== 1'b0) begin
            errors++; $display("FAIL ignore_frame: sync=%0d writes=%0d viol=%0d timeout=%0d want 1/48/0/0", n_sync, n_wr, viol, tmo);
        end
        for (int i = 0; i < 48; i++) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL ignore_byte%0d: got %h want %h", i, g, e); end
        end
        extra = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr || sync || !rdy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL ignore_no_requeue: busy/strobe cycles=%0d want 0", extra); end
    endtask

    task automatic test_stall;
        int n_wr, n_sync, viol, gap; bit tmo; logic [7:0] e, g;
        exp_q.delete();
        push_frame(1'b0, 24'h987654);
        stall_at = 10;
        start_refresh(24'h987654);
        capture(0, 0, n_wr, n_sync, viol, gap, tmo);
        stall_at = 0;
        checks++; if (n_sync !== 1 || n_wr !== 48 || viol !== 0 || tmo !== 1'b0) begin
            errors++; $display("FAIL stall_frame: sync=%0d writes=%0d viol=%0d timeout=%0d want 1/48/0/0", n_sync, n_wr, viol, tmo);
        end
        checks++; if (gap < 100) begin errors++; $display("FAIL stall_gap: max strobe gap=%0d want >=100", gap); end
        for (int i = 0; i < 48; i++) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL stall_byte%0d: got %h want %h", i, g, e); end
        end
    endtask

    task automatic test_reset_mid;
        int n_wr, n_sync, viol, gap; bit tmo; logic [7:0] e, g;
        start_refresh(24'h123456);
        capture(20, 0, n_wr, n_sync, viol, gap, tmo);
        checks++; if (n_wr !== 20 || tmo !== 1'b0 || wr !== 1'b1 || data !== 8'h45) begin
            errors++; $display("FAIL midreset_partial: writes=%0d timeout=%0d wr=%b data=%h want 20/0/1/45", n_wr, tmo, wr, data);
        end
        #2 rstn = 1'b0;
        #1;
        checks++; if (rdy !== 1'b1 || wr !== 1'b0 || sync !== 1'b0 || data !== 8'h00) begin
            errors++; $display("FAIL midreset_async: ready=%b wr=%b sync=%b data=%h want 1/0/0/00", rdy, wr, sync, data);
        end
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        exp_q.delete(); exp_nb_q.delete();
        push_frame(1'b0, 24'hFFF789);
        push_frame(1'b1, 24'h000789);
        start_refresh(24'h000789);
        capture(0, 0, n_wr, n_sync, viol, gap, tmo);
        checks++; if (n_sync !== 1 || n_wr !== 48 || viol !== 0 || tmo !== 1'b0) begin
            errors++; $display("FAIL midreset_frame: sync=%0d writes=%0d viol=%0d timeout=%0d want 1/48/0/0", n_sync, n_wr, viol, tmo);
        end
        for (int i = 0; i < 48; i++) begin
            e = exp_q.pop_front(); g = (got_q.size() > 0) ? got_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL midreset_byte%0d: got %h want %h", i, g, e); end
            e = exp_nb_q.pop_front(); g = (got_nb_q.size() > 0) ? got_nb_q.pop_front() : 8'hxx;
            checks++; if (g !== e) begin errors++; $display("FAIL midreset_nb_byte%0d: got %h want %h", i, g, e); end
        end
    endtask

    initial begin
        test_reset;
        test_value42;
        test_zero;
        test_dash;
        test_ignore_refresh;
        test_stall;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
